// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game: state encoding,
// difficulty-indexed timing tables and LFSR parameters.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        UP    = 2'd2,
        FLASH = 2'd3
    } state_t;

    localparam int MS_W = 10;

    // Element [d] is the time in ms for difficulty d (element 0 is rightmost).
    localparam logic [3:0][MS_W-1:0] UP_MS  = {10'd300, 10'd450, 10'd700, 10'd1000};
    localparam logic [3:0][MS_W-1:0] GAP_MS = {10'd150, 10'd250, 10'd400, 10'd600};
    localparam logic [MS_W-1:0]      FLASH_MS = 10'd100;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reseeded only by reset.
module lfsr16
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    // NOTE: registered state is always written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= LFSR_SEED;
        end else begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Mole sequencing FSM: picks a pseudo-random mole, times GAP/UP/FLASH phases
// in milliseconds and judges whack pulses into hit/miss/wrong scoring pulses.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int NUM_MOLES = 8,
    parameter int IDXW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           difficulty_level,
    input  logic                 tick_ms,
    input  logic [NUM_MOLES-1:0] whack,
    output logic [NUM_MOLES-1:0] mole_leds,
    output logic [IDXW-1:0]      active_idx,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 wrong_pulse,
    output logic [7:0]           mole_count
);

    localparam logic [IDXW:0]      NM  = (IDXW+1)'(NUM_MOLES);
    localparam logic [NUM_MOLES-1:0] ONE = NUM_MOLES'(1);

    state_t          state, next_state;
    logic [MS_W-1:0] ms_cnt, up_lim, gap_lim, limit;
    logic [15:0]     lfsr;
    logic            lfsr_unused;
    logic            expire, any_whack;
    logic            hit, miss, wrong, gap_entry, up_entry;
    logic [IDXW:0]   cand_raw, cand_fold, cand_bump;
    logic [IDXW-1:0] pick;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:IDXW];

    always_comb begin
        case (state)
            GAP:     limit = gap_lim;
            UP:      limit = up_lim;
            default: limit = FLASH_MS;
        endcase
    end

    assign expire    = tick_ms && (ms_cnt == limit - 1'b1);
    assign any_whack = |whack;

    // Fold the raw candidate into range, then step past the previous mole.
    assign cand_raw  = {1'b0, lfsr[IDXW-1:0]};
    assign cand_fold = (cand_raw >= NM) ? cand_raw - NM : cand_raw;
    assign cand_bump = (cand_fold[IDXW-1:0] == active_idx) ? cand_fold + 1'b1 : cand_fold;
    assign pick      = (cand_bump == NM) ? '0 : cand_bump[IDXW-1:0];

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        miss       = 1'b0;
        wrong      = 1'b0;
        gap_entry  = 1'b0;
        up_entry   = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    next_state = GAP;
                    gap_entry  = 1'b1;
                end
                GAP: begin
                    wrong = any_whack;
                    if (expire) begin
                        next_state = UP;
                        up_entry   = 1'b1;
                    end
                end
                UP: begin
                    if (|(whack & mole_leds)) begin
                        hit        = 1'b1;
                        next_state = FLASH;
                    end else if (expire) begin
                        miss       = 1'b1;
                        next_state = GAP;
                        gap_entry  = 1'b1;
                    end else begin
                        wrong = any_whack;
                    end
                end
                FLASH: begin
                    wrong = any_whack;
                    if (expire) begin
                        next_state = GAP;
                        gap_entry  = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ms_cnt      <= '0;
            up_lim      <= '0;
            gap_lim     <= '0;
            mole_leds   <= '0;
            active_idx  <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
            mole_count  <= '0;
        end else begin
            state       <= next_state;
            hit_pulse   <= hit;
            miss_pulse  <= miss;
            wrong_pulse <= wrong;

            if (next_state != state || state == IDLE) begin
                ms_cnt <= '0;
            end else if (tick_ms) begin
                ms_cnt <= ms_cnt + 1'b1;
            end

            // Both phase times are frozen at GAP entry for the whole GAP/UP pair.
            if (gap_entry) begin
                up_lim  <= UP_MS[difficulty_level];
                gap_lim <= GAP_MS[difficulty_level];
            end

            case (next_state)
                UP:      if (up_entry) mole_leds <= ONE << pick;
                FLASH:   mole_leds <= '1;
                default: mole_leds <= '0;
            endcase

            if (up_entry) begin
                active_idx <= pick;
                mole_count <= (mole_count == 8'hFF) ? mole_count : mole_count + 8'd1;
            end else if (state == IDLE && gap_entry) begin
                mole_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler: a default 8-mole instance
// and a 6-mole instance for the long selection/saturation run.
module tb_mole_scheduler;

    localparam int W_ON        = 0;
    localparam int W_NOT_FLASH = 1;
    localparam int W_MISS      = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, tick_ms;
    logic [1:0] difficulty_level;
    logic [7:0] whack, mole_leds;
    logic [3:0] active_idx;
    logic       hit_pulse, miss_pulse, wrong_pulse;
    logic [7:0] mole_count;

    logic       rst6, enable6, tick6;
    logic [1:0] diff6;
    logic [5:0] whack6, leds6;
    logic [2:0] idx6;
    logic       hit6, miss6, wrong6;
    logic [7:0] count6;

    mole_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .difficulty_level (difficulty_level),
        .tick_ms          (tick_ms),
        .whack            (whack),
        .mole_leds        (mole_leds),
        .active_idx       (active_idx),
        .hit_pulse        (hit_pulse),
        .miss_pulse       (miss_pulse),
        .wrong_pulse      (wrong_pulse),
        .mole_count       (mole_count)
    );

    mole_scheduler #(.NUM_MOLES(6), .IDXW(3)) dut6 (
        .clk              (clk),
        .rst              (rst6),
        .enable           (enable6),
        .difficulty_level (diff6),
        .tick_ms          (tick6),
        .whack            (whack6),
        .mole_leds        (leds6),
        .active_idx       (idx6),
        .hit_pulse        (hit6),
        .miss_pulse       (miss6),
        .wrong_pulse      (wrong6),
        .mole_count       (count6)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int tick_period = 1;
    int tick_phase  = 0;
    int tick_total  = 0;
    int prev_idx, prev6, exp_count, mark, t, e;

    // Reference LFSR; *_used holds the value seen during the cycle just ended.
    logic [15:0] lf, lf_used, lf6, lf6_used;

    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    always @(posedge clk) begin
        lf_used  <= lf;
        lf6_used <= lf6;
        lf       <= rst  ? 16'hACE1 : lfsr_step(lf);
        lf6      <= rst6 ? 16'hACE1 : lfsr_step(lf6);
    end

    function automatic int expect_idx(input logic [15:0] l, input int nm, input int w, input int prev);
        int c;
        c = int'(l) & ((1 << w) - 1);
        if (c >= nm) c = c - nm;
        if (c == prev) c = c + 1;
        if (c == nm) c = 0;
        return c;
    endfunction

    function automatic logic [7:0] oh8(input int i);
        return 8'd1 << i;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        tick_ms    = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % tick_period;
        if (tick_ms) tick_total++;
        @(posedge clk);
        @(negedge clk);
        whack  = '0;
        whack6 = '0;
    endtask

    function automatic bit cond(input int what);
        case (what)
            W_ON:        return mole_leds != 8'h00;
            W_NOT_FLASH: return mole_leds != 8'hFF;
            default:     return miss_pulse == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int what, input string tag, input int from, output int ticks);
        for (int i = 0; i < 5000 && !cond(what); i++) cyc();
        check({tag, "_reached"}, cond(what), 1);
        ticks = tick_total - from;
    endtask

    task automatic note_mole(input string tag);
        int ei;
        ei = expect_idx(lf_used, 8, 4, prev_idx);
        check({tag, "_idx"}, active_idx, ei);
        check({tag, "_differs"}, int'(active_idx) != prev_idx, 1);
        check({tag, "_leds"}, mole_leds, oh8(ei));
        exp_count++;
        check({tag, "_count"}, mole_count, exp_count);
        prev_idx = ei;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; difficulty_level = 2'd0; tick_ms = 1'b0; whack = '0;
        rst6 = 1'b1; enable6 = 1'b0; diff6 = 2'd3; tick6 = 1'b1; whack6 = '0;
        prev_idx = 0; prev6 = 0; exp_count = 0;

        // Reset state
        repeat (3) cyc();
        check("rst_leds", mole_leds, 0);
        check("rst_idx", active_idx, 0);
        check("rst_hit", hit_pulse, 0);
        check("rst_miss", miss_pulse, 0);
        check("rst_wrong", wrong_pulse, 0);
        check("rst_count", mole_count, 0);
        rst = 1'b0; rst6 = 1'b0;
        cyc();

        // Difficulty 0, ticks every other cycle, no whacks: 600 GAP, 1000 UP, miss
        tick_period = 2; tick_phase = 0;
        enable = 1'b1;
        cyc();
        check("gap_leds_off", mole_leds, 0);
        mark = tick_total;
        wait_for(W_ON, "first_up", mark, t);
        check("gap_d0_ticks", t, 600);
        note_mole("m1");
        mark = tick_total;
        wait_for(W_MISS, "first_miss", mark, t);
        check("up_d0_ticks", t, 1000);
        check("miss_leds", mole_leds, 0);
        check("miss_count", mole_count, 1);
        check("miss_no_hit", hit_pulse, 0);

        // Difficulty change mid-GAP only applies at the next GAP entry
        difficulty_level = 2'd3;
        tick_period = 1; tick_phase = 0;
        mark = tick_total;
        cyc();
        check("miss_width", miss_pulse, 0);
        wait_for(W_ON, "gap_latched", mark, t);
        check("gap_latched_ticks", t, 600);
        note_mole("m2");

        // Hit 10 ticks into UP, then 100-tick FLASH and 150-tick GAP
        repeat (10) cyc();
        whack = mole_leds;
        cyc();
        check("hit_pulse", hit_pulse, 1);
        check("hit_flash_leds", mole_leds, 8'hFF);
        check("hit_no_miss", miss_pulse, 0);
        check("hit_no_wrong", wrong_pulse, 0);
        check("hit_idx_hold", active_idx, prev_idx);
        mark = tick_total;
        cyc();
        check("hit_width", hit_pulse, 0);
        wait_for(W_NOT_FLASH, "flash_end", mark, t);
        check("flash_ticks", t, 100);
        check("flash_to_gap_leds", mole_leds, 0);
        mark = tick_total;
        wait_for(W_ON, "gap_d3", mark, t);
        check("gap_d3_ticks", t, 150);
        note_mole("m3");

        // Wrong whack in UP, combined whack, wrong in FLASH and GAP
        repeat (2) cyc();
        whack = oh8((prev_idx + 4) % 8);
        cyc();
        check("wrong_up", wrong_pulse, 1);
        check("wrong_up_no_hit", hit_pulse, 0);
        check("wrong_up_leds", mole_leds, oh8(prev_idx));
        cyc();
        check("wrong_width", wrong_pulse, 0);
        whack = oh8(prev_idx) | oh8((prev_idx + 4) % 8);
        cyc();
        check("combo_hit", hit_pulse, 1);
        check("combo_no_wrong", wrong_pulse, 0);
        check("combo_leds", mole_leds, 8'hFF);
        mark = tick_total;
        whack = 8'h01;
        cyc();
        check("wrong_flash", wrong_pulse, 1);
        check("wrong_flash_leds", mole_leds, 8'hFF);
        wait_for(W_NOT_FLASH, "flash2_end", mark, t);
        check("flash2_ticks", t, 100);
        mark = tick_total;
        whack = 8'h80;
        cyc();
        check("wrong_gap", wrong_pulse, 1);
        check("wrong_gap_leds", mole_leds, 0);
        wait_for(W_ON, "gap_after_wrong", mark, t);
        check("gap_after_wrong_ticks", t, 150);
        note_mole("m4");

        // Hit on the final tick of a 300-tick UP wins over the miss
        repeat (299) cyc();
        check("pre_final_leds", mole_leds, oh8(prev_idx));
        whack = mole_leds;
        cyc();
        check("final_tick_hit", hit_pulse, 1);
        check("final_tick_no_miss", miss_pulse, 0);
        check("final_tick_leds", mole_leds, 8'hFF);
        mark = tick_total;
        wait_for(W_NOT_FLASH, "flash3_end", mark, t);
        mark = tick_total;
        wait_for(W_ON, "gap3", mark, t);
        note_mole("m5");
        mark = tick_total;
        wait_for(W_MISS, "miss_d3", mark, t);
        check("up_d3_ticks", t, 300);

        // Drop enable together with a hit: no pulses, count and index held
        mark = tick_total;
        wait_for(W_ON, "gap4", mark, t);
        note_mole("m6");
        repeat (5) cyc();
        enable = 1'b0;
        whack = mole_leds;
        cyc();
        check("drop_leds", mole_leds, 0);
        check("drop_no_hit", hit_pulse, 0);
        check("drop_no_miss", miss_pulse, 0);
        check("drop_no_wrong", wrong_pulse, 0);
        check("drop_count_held", mole_count, exp_count);
        check("drop_idx_held", active_idx, prev_idx);
        whack = 8'hFF;
        cyc();
        check("idle_whack_ignored", wrong_pulse, 0);
        check("idle_leds", mole_leds, 0);
        enable = 1'b1;
        cyc();
        check("reenable_count_clear", mole_count, 0);
        check("reenable_leds", mole_leds, 0);
        exp_count = 0;
        mark = tick_total;
        wait_for(W_ON, "gap_reenable", mark, t);
        check("gap_reenable_ticks", t, 150);
        note_mole("m7");

        // Reset mid-UP: LEDs off, no pulses, LFSR reseeded
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        check("rst_mid_leds", mole_leds, 0);
        check("rst_mid_hit", hit_pulse, 0);
        check("rst_mid_miss", miss_pulse, 0);
        check("rst_mid_wrong", wrong_pulse, 0);
        check("rst_mid_idx", active_idx, 0);
        check("rst_mid_count", mole_count, 0);
        prev_idx = 0; exp_count = 0;
        rst = 1'b0;
        cyc();
        mark = tick_total;
        wait_for(W_ON, "gap_after_rst", mark, t);
        check("gap_after_rst_ticks", t, 150);
        note_mole("m8");
        enable = 1'b0;
        cyc();

        // Six-mole instance: long run of immediate hits until the count saturates
        enable6 = 1'b1;
        cyc();
        for (int m = 0; m < 260; m++) begin
            for (int i = 0; i < 400 && (leds6 == 6'h00 || leds6 == 6'h3F); i++) cyc();
            check("six_up", leds6 != 6'h00 && leds6 != 6'h3F, 1);
            e = expect_idx(lf6_used, 6, 3, prev6);
            check("six_idx", idx6, e);
            check("six_range", idx6 < 3'd6, 1);
            check("six_differs", int'(idx6) != prev6, 1);
            check("six_leds", leds6, 6'd1 << e);
            check("six_count", count6, (m + 1 > 255) ? 255 : m + 1);
            prev6 = e;
            whack6 = leds6;
            cyc();
            check("six_hit", hit6, 1);
        end
        check("six_saturated", count6, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
